lap_tracker: RTL and testbench



---
 rtl/lap_tracker_pkg.sv | 20 ++
 rtl/lap_tracker_zone_match.sv | 18 +
 rtl/lap_tracker.sv | 179 +++++++++++++++++
 tb/tb_lap_tracker.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lap_tracker_pkg.sv
// Shared types for the lap/checkpoint tracker: zone box layout,
// race state encoding and coordinate width.
package lap_tracker_pkg;

    localparam int COORD_W = 11;

    typedef struct packed {
        logic [COORD_W-1:0] x_min;
        logic [COORD_W-1:0] x_max;
        logic [COORD_W-1:0] y_min;
        logic [COORD_W-1:0] y_max;
    } zone_t;

    typedef enum logic [1:0] {
        IDLE,
        RACING,
        FINISHED
    } state_t;

endpackage

// File: rtl/lap_tracker_zone_match.sv
// Combinational box-inside-zone test; all bounds unsigned and inclusive.
import lap_tracker_pkg::*;

module zone_match (
    input  logic [COORD_W-1:0] i_x_start,
    input  logic [COORD_W-1:0] i_x_end,
    input  logic [COORD_W-1:0] i_y_start,
    input  logic [COORD_W-1:0] i_y_end,
    input  zone_t              i_zone,
    output logic               o_hit
);

    assign o_hit = (i_x_start >= i_zone.x_min) &&
                   (i_x_end   <= i_zone.x_max) &&
                   (i_y_start >= i_zone.y_min) &&
                   (i_y_end   <= i_zone.y_max);

endmodule

// File: rtl/lap_tracker.sv
// Lap/checkpoint tracker for one car: laps, lap timing, race end.
// Optional best-lap register enabled by LAP_TRACKER_BEST_LAP_EN.
import lap_tracker_pkg::*;

module lap_tracker #(
    parameter int NUM_CP      = 6,
    parameter int ORDERED     = 1,
    parameter int LAP_W       = 4,
    parameter int TARGET_LAPS = 3,
    parameter int TIME_W      = 16
) (
    input  logic                   pclk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   frame_tick,
    input  logic [COORD_W-1:0]     car_x_start,
    input  logic [COORD_W-1:0]     car_x_end,
    input  logic [COORD_W-1:0]     car_y_start,
    input  logic [COORD_W-1:0]     car_y_end,
    input  logic [44*NUM_CP-1:0]   cp_bounds,
    input  logic [43:0]            fin_bounds,
    output logic [NUM_CP-1:0]      cp_mask,
    output logic [4:0]             next_cp,
    output logic [LAP_W-1:0]       lap_count,
    output logic                   lap_done,
    output logic                   invalid_cross,
    output logic                   race_done,
    output logic [TIME_W-1:0]      last_lap_time,
    output logic [TIME_W-1:0]      best_lap_time
);

    state_t              r_state;
    state_t              w_state_nx;
    logic                r_in_fin_q;
    logic [NUM_CP-1:0]   r_cp_mask;
    logic [4:0]          r_next_cp;
    logic [LAP_W-1:0]    r_lap_count;
    logic                r_lap_done;
    logic                r_invalid;
    logic [TIME_W-1:0]   r_timer;
    logic [TIME_W-1:0]   r_last;

    logic [NUM_CP-1:0]   w_hit;
    logic                w_in_fin;
    logic                w_in_race;
    logic                w_entry;
    logic                w_full;
    logic                w_lap_ok;
    logic                w_bad;
    logic                w_last_lap;
    logic [NUM_CP-1:0]   w_mask_nx;
    logic [4:0]          w_next_nx;

    for (genvar g = 0; g < NUM_CP; g++) begin : g_cp
        zone_match u_cp (
            .i_x_start (car_x_start),
            .i_x_end   (car_x_end),
            .i_y_start (car_y_start),
            .i_y_end   (car_y_end),
            .i_zone    (zone_t'(cp_bounds[44*g +: 44])),
            .o_hit     (w_hit[g])
        );
    end

    zone_match u_fin (
        .i_x_start (car_x_start),
        .i_x_end   (car_x_end),
        .i_y_start (car_y_start),
        .i_y_end   (car_y_end),
        .i_zone    (zone_t'(fin_bounds)),
        .o_hit     (w_in_fin)
    );

    assign w_in_race  = (r_state == RACING) && !start;
    assign w_entry    = w_in_fin && !r_in_fin_q;
    assign w_full     = &r_cp_mask;
    assign w_lap_ok   = w_in_race && w_entry && w_full;
    assign w_bad      = w_in_race && w_entry && !w_full;
    assign w_last_lap = w_lap_ok &&
                        (r_lap_count == LAP_W'(TARGET_LAPS - 1));

    // Ordered mode: only the zone at next_cp may advance, one per cycle
    if (ORDERED != 0) begin : g_ord
        logic [NUM_CP-1:0] w_cp_set;
        logic [5:0]        w_next_inc;

        always_comb begin
            w_cp_set = '0;
            for (int i = 0; i < NUM_CP; i++)
                w_cp_set[i] = w_hit[i] && (r_next_cp == 5'(i));
        end

        assign w_next_inc = {1'b0, r_next_cp} + 6'd1;
        assign w_mask_nx  = r_cp_mask | w_cp_set;
        assign w_next_nx  = !(|w_cp_set) ? r_next_cp :
                            w_next_inc[5] ? 5'd31 : w_next_inc[4:0];
    end else begin : g_any
        assign w_mask_nx = r_cp_mask | w_hit;
        assign w_next_nx = '0;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:     if (start) w_state_nx = RACING;
            RACING: begin
                if (start)           w_state_nx = RACING;
                else if (w_last_lap) w_state_nx = FINISHED;
            end
            FINISHED: if (start) w_state_nx = RACING;
            default:  w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_in_fin_q  <= 1'b0;
            r_cp_mask   <= '0;
            r_next_cp   <= '0;
            r_lap_count <= '0;
            r_lap_done  <= 1'b0;
            r_invalid   <= 1'b0;
            r_timer     <= '0;
            r_last      <= '0;
        end else begin
            r_in_fin_q <= w_in_fin;
            r_lap_done <= w_lap_ok;
            r_invalid  <= w_bad;
            if (start) begin
                r_cp_mask   <= '0;
                r_next_cp   <= '0;
                r_lap_count <= '0;
                r_timer     <= '0;
                r_last      <= '0;
            end else if (w_lap_ok) begin
                // same-cycle checkpoint hit and tick are dropped
                r_lap_count <= r_lap_count + 1'b1;
                r_last      <= r_timer;
                r_cp_mask   <= '0;
                r_next_cp   <= '0;
                r_timer     <= '0;
            end else if (w_in_race) begin
                r_cp_mask <= w_mask_nx;
                r_next_cp <= w_next_nx;
                if (frame_tick && (r_timer != '1))
                    r_timer <= r_timer + 1'b1;
            end
        end
    end

`ifdef LAP_TRACKER_BEST_LAP_EN
    logic [TIME_W-1:0] r_best;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst)
            r_best <= '1;
        else if (w_lap_ok && (r_timer < r_best))
            r_best <= r_timer;
    end

    assign best_lap_time = r_best;
`else
    assign best_lap_time = '1;
`endif

    assign cp_mask       = r_cp_mask;
    assign next_cp       = r_next_cp;
    assign lap_count     = r_lap_count;
    assign lap_done      = r_lap_done;
    assign invalid_cross = r_invalid;
    assign race_done     = (r_state == FINISHED);
    assign last_lap_time = r_last;

endmodule

// File: tb/tb_lap_tracker.sv
// Bench for lap_tracker: ordered and any-order instances share stimulus
// and are checked against an integer-level race model.
module tb_lap_tracker;

    localparam int NCP  = 4;
    localparam int LW   = 4;
    localparam int TL   = 2;
    localparam int TW   = 16;
    localparam int TMAX = (1 << TW) - 1;
    localparam int S_IDLE = 0;
    localparam int S_RACE = 1;
    localparam int S_FIN  = 2;
`ifdef LAP_TRACKER_BEST_LAP_EN
    localparam bit BEST_EN = 1'b1;
`else
    localparam bit BEST_EN = 1'b0;
`endif

    logic              pclk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              frame_tick = 1'b0;
    logic [10:0]       cxs, cxe, cys, cye;
    logic [44*NCP-1:0] cp_bounds;
    logic [43:0]       fin_bounds;

    logic [NCP-1:0] d_mask [2];
    logic [4:0]     d_next [2];
    logic [LW-1:0]  d_laps [2];
    logic           d_done [2];
    logic           d_inv  [2];
    logic           d_race [2];
    logic [TW-1:0]  d_last [2];
    logic [TW-1:0]  d_best [2];

    always #5 pclk = ~pclk;

    lap_tracker #(
        .NUM_CP(NCP), .ORDERED(1), .LAP_W(LW),
        .TARGET_LAPS(TL), .TIME_W(TW)
    ) u_ord (
        .pclk(pclk), .rst(rst), .start(start), .frame_tick(frame_tick),
        .car_x_start(cxs), .car_x_end(cxe),
        .car_y_start(cys), .car_y_end(cye),
        .cp_bounds(cp_bounds), .fin_bounds(fin_bounds),
        .cp_mask(d_mask[0]), .next_cp(d_next[0]),
        .lap_count(d_laps[0]), .lap_done(d_done[0]),
        .invalid_cross(d_inv[0]), .race_done(d_race[0]),
        .last_lap_time(d_last[0]), .best_lap_time(d_best[0])
    );

    lap_tracker #(
        .NUM_CP(NCP), .ORDERED(0), .LAP_W(LW),
        .TARGET_LAPS(TL), .TIME_W(TW)
    ) u_any (
        .pclk(pclk), .rst(rst), .start(start), .frame_tick(frame_tick),
        .car_x_start(cxs), .car_x_end(cxe),
        .car_y_start(cys), .car_y_end(cye),
        .cp_bounds(cp_bounds), .fin_bounds(fin_bounds),
        .cp_mask(d_mask[1]), .next_cp(d_next[1]),
        .lap_count(d_laps[1]), .lap_done(d_done[1]),
        .invalid_cross(d_inv[1]), .race_done(d_race[1]),
        .last_lap_time(d_last[1]), .best_lap_time(d_best[1])
    );

    // zones 0..3 are checkpoints, zone 4 is the finish (overlaps zone 0)
    int zx0 [5] = '{0,   100, 200, 100, 0};
    int zx1 [5] = '{60,  160, 260, 360, 60};
    int zy0 [5] = '{0,   0,   0,   0,   40};
    int zy1 [5] = '{60,  60,  60,  60,  160};

    // 0:z0 1:z1+z3 2:z2+z3 3:z3 4:fin 5:none
    // 6:z0 exact 7:one past z0 8:fin exact 9:z0+fin
    int px0 [10] = '{20, 120, 220, 320, 20,  700, 0,  0,  0,   20};
    int px1 [10] = '{30, 130, 230, 330, 30,  710, 60, 61, 60,  30};
    int py0 [10] = '{10, 10,  10,  10,  120, 10,  0,  0,  40,  45};
    int py1 [10] = '{20, 20,  20,  20,  130, 20,  60, 60, 160, 55};

    int n_chk = 0;
    int n_err = 0;

    int m_state [2];
    int m_mask  [2];
    int m_next  [2];
    int m_laps  [2];
    int m_timer [2];
    int m_last  [2];
    int m_best  [2];
    bit m_done  [2];
    bit m_inv   [2];
    bit m_prev_fin;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit inside_zone(input int pos, input int z);
        return px0[pos] >= zx0[z] && px1[pos] <= zx1[z] &&
               py0[pos] >= zy0[z] && py1[pos] <= zy1[z];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_state[d] = S_IDLE;
            m_mask[d]  = 0;
            m_next[d]  = 0;
            m_laps[d]  = 0;
            m_timer[d] = 0;
            m_last[d]  = 0;
            m_best[d]  = TMAX;
            m_done[d]  = 0;
            m_inv[d]   = 0;
        end
        m_prev_fin = 0;
    endtask

    task automatic model_step(input bit st, input bit tk, input int pos);
        int hits;
        bit fin, entry;
        hits = 0;
        for (int z = 0; z < NCP; z++)
            if (inside_zone(pos, z)) hits = hits | (1 << z);
        fin   = inside_zone(pos, NCP);
        entry = fin && !m_prev_fin;
        for (int d = 0; d < 2; d++) begin
            m_done[d] = 0;
            m_inv[d]  = 0;
            if (st) begin
                m_state[d] = S_RACE;
                m_mask[d]  = 0;
                m_next[d]  = 0;
                m_laps[d]  = 0;
                m_timer[d] = 0;
                m_last[d]  = 0;
            end else if (m_state[d] == S_RACE) begin
                if (entry && m_mask[d] == (1 << NCP) - 1) begin
                    m_done[d] = 1;
                    m_laps[d]++;
                    m_last[d] = m_timer[d];
                    if (BEST_EN && m_timer[d] < m_best[d])
                        m_best[d] = m_timer[d];
                    m_mask[d]  = 0;
                    m_next[d]  = 0;
                    m_timer[d] = 0;
                    if (m_laps[d] == TL) m_state[d] = S_FIN;
                end else begin
                    if (entry) m_inv[d] = 1;
                    if (d == 0) begin
                        if (m_next[d] < NCP && ((hits >> m_next[d]) & 1) == 1) begin
                            m_mask[d] = m_mask[d] | (1 << m_next[d]);
                            m_next[d]++;
                        end
                    end else begin
                        m_mask[d] = m_mask[d] | hits;
                    end
                    if (tk && m_timer[d] < TMAX) m_timer[d]++;
                end
            end
        end
        m_prev_fin = fin;
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("mask%0d", d), 32'(d_mask[d]), 32'(m_mask[d]));
            chk($sformatf("next%0d", d), 32'(d_next[d]), 32'(m_next[d]));
            chk($sformatf("laps%0d", d), 32'(d_laps[d]), 32'(m_laps[d]));
            chk($sformatf("done%0d", d), 32'(d_done[d]), 32'(m_done[d]));
            chk($sformatf("inv%0d", d), 32'(d_inv[d]), 32'(m_inv[d]));
            chk($sformatf("race%0d", d), 32'(d_race[d]),
                32'(m_state[d] == S_FIN));
            chk($sformatf("last%0d", d), 32'(d_last[d]), 32'(m_last[d]));
            chk($sformatf("best%0d", d), 32'(d_best[d]), 32'(m_best[d]));
        end
    endtask

    task automatic set_pos(input int pos);
        cxs = 11'(px0[pos]);
        cxe = 11'(px1[pos]);
        cys = 11'(py0[pos]);
        cye = 11'(py1[pos]);
    endtask

    // called just after a falling edge
    task automatic cyc(input bit st, input bit tk, input int pos);
        start      = st;
        frame_tick = tk;
        set_pos(pos);
        model_step(st, tk, pos);
        @(posedge pclk);
        @(negedge pclk);
        compare_all();
    endtask

    task automatic do_reset();
        start      = 1'b0;
        frame_tick = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_mask", 32'(d_mask[0]), 32'd0);
        chk("rst_laps", 32'(d_laps[1]), 32'd0);
        chk("rst_best", 32'(d_best[0]), 32'hFFFF);
        compare_all();
        @(negedge pclk);
        rst = 1'b0;
    endtask

    task automatic visit_all();
        cyc(0, 0, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 2);
        cyc(0, 0, 3);
    endtask

    task automatic run_lap(input int ticks);
        visit_all();
        repeat (ticks) cyc(0, 1, 5);
        cyc(0, 0, 4);
        cyc(0, 0, 5);
    endtask

    initial begin
        int pos, hold;
        for (int i = 0; i < NCP; i++)
            cp_bounds[44*i +: 44] = {11'(zx0[i]), 11'(zx1[i]),
                                     11'(zy0[i]), 11'(zy1[i])};
        fin_bounds = {11'(zx0[NCP]), 11'(zx1[NCP]),
                      11'(zy0[NCP]), 11'(zy1[NCP])};
        set_pos(5);
        model_reset();
        repeat (2) @(negedge pclk);
        compare_all();
        rst = 1'b0;

        // full ordered lap of 120 ticks
        cyc(1, 0, 5);
        visit_all();
        repeat (120) cyc(0, 1, 5);
        cyc(0, 0, 4);
        chk("t1_done", 32'(d_done[0]), 32'd1);
        chk("t1_laps", 32'(d_laps[0]), 32'd1);
        chk("t1_last", 32'(d_last[0]), 32'd120);
        chk("t1_mask", 32'(d_mask[0]), 32'd0);
        cyc(0, 0, 5);

        // out-of-order hit ignored when ordered
        cyc(1, 0, 5);
        cyc(0, 0, 2);
        chk("t2_mask0", 32'(d_mask[0]), 32'd0);
        chk("t2_next0", 32'(d_next[0]), 32'd0);
        visit_all();
        chk("t2_mask", 32'(d_mask[0]), 32'hF);
        chk("t2_next", 32'(d_next[0]), 32'd4);
        cyc(0, 0, 5);

        // shortcut across finish, then dwell
        cyc(1, 0, 5);
        cyc(0, 0, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 2);
        cyc(0, 0, 4);
        chk("t3_inv", 32'(d_inv[0]), 32'd1);
        chk("t3_laps", 32'(d_laps[0]), 32'd0);
        chk("t3_mask", 32'(d_mask[0]), 32'h7);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 4);
            chk("t3_dwell", 32'(d_inv[0]), 32'd0);
        end
        cyc(0, 0, 5);

        // race to the end: 200 then 150
        do_reset();
        cyc(1, 0, 5);
        run_lap(200);
        run_lap(150);
        chk("t4_race", 32'(d_race[0]), 32'd1);
        chk("t4_laps", 32'(d_laps[0]), 32'd2);
        chk("t4_best", 32'(d_best[0]), BEST_EN ? 32'd150 : 32'hFFFF);
        for (int i = 0; i < 40; i++)
            cyc(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 9)));
        chk("t4_hold", 32'(d_laps[1]), 32'd2);
        cyc(1, 0, 5);
        chk("t4_rearm", 32'(d_laps[0]), 32'd0);
        chk("t4_keep", 32'(d_best[0]), BEST_EN ? 32'd150 : 32'hFFFF);

        // checkpoint 0 plus tick in the same cycle as a valid finish
        cyc(1, 0, 5);
        visit_all();
        repeat (5) cyc(0, 1, 5);
        cyc(0, 1, 9);
        chk("t5_done", 32'(d_done[0]), 32'd1);
        chk("t5_mask0", 32'(d_mask[0]), 32'd0);
        chk("t5_mask1", 32'(d_mask[1]), 32'd0);
        cyc(0, 0, 5);
        run_lap(7);
        chk("t5_last", 32'(d_last[0]), 32'd7);

        // reset mid-lap, then overlapping zones in any-order mode
        cyc(1, 0, 5);
        cyc(0, 0, 0);
        cyc(0, 1, 1);
        do_reset();
        cyc(1, 0, 5);
        cyc(0, 0, 1);
        chk("t6_any", 32'(d_mask[1]), 32'hA);

        // inclusive bounds
        cyc(1, 0, 5);
        cyc(0, 0, 7);
        chk("edge_out", 32'(d_mask[0]), 32'd0);
        cyc(0, 0, 6);
        chk("edge_in", 32'(d_mask[0]), 32'd1);
        cyc(0, 0, 8);
        chk("edge_fin", 32'(d_inv[0]), 32'd1);
        cyc(0, 0, 5);

        // randomized racing
        pos  = 5;
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 1999) == 0) do_reset();
            if (hold == 0) begin
                hold = int'($urandom_range(1, 3));
                if ($urandom_range(0, 2) == 0)
                    pos = (m_next[0] < NCP) ? m_next[0] : 4;
                else
                    pos = int'($urandom_range(0, 9));
            end
            hold--;
            cyc(1'($urandom_range(0, 149) == 0),
                1'($urandom_range(0, 1)), pos);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
